mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction port) and the memory stage (data port).
- Serialises accesses and returns read data with a one-cycle ack pulse. Requesters use the ack to stall their pipeline stage.
- Data port has priority (older instruction). A streak counter bounds instruction starvation.
- A branch-kill input discards an in-flight fetch.

---
 rtl/mem_arbiter_if.sv | 53 +++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Instruction/data request ports, shared memory command bus
//                and status for mem_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_kill;
    logic        i_ack;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ack;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic        busy;

    // Arbiter view: takes requests and memory read data, drives everything else.
    modport slave (
        input  i_req, i_addr, i_kill,
        output i_ack, i_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        output d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata,
        output busy
    );

    modport master (
        output i_req, i_addr, i_kill,
        input  i_ack, i_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be,
        input  d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares a fixed-latency single-port memory between fetch and
//                data ports; data has priority, instruction starvation bounded.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MEM_LATENCY     = 2,
    parameter int MAX_DATA_STREAK = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] c_lat_load   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] c_max_streak = 4'(MAX_DATA_STREAK);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_streak;
    logic        r_kill;
    logic        r_owner_i;
    logic        r_store;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;

    logic        w_idle;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_kill_now;

    assign w_idle    = (r_state == S_IDLE);
    // Grants are gated by rst so the combinational command bus is quiet in reset.
    assign w_grant_i = ~rst & w_idle & bus.i_req & ~bus.i_kill
                       & (~bus.d_req | (r_streak == c_max_streak));
    assign w_grant_d = ~rst & w_idle & bus.d_req & ~w_grant_i;
    assign w_kill_now = r_kill | bus.i_kill;

    always_comb begin
        bus.mem_en    = w_grant_i | w_grant_d;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_be    = 4'd0;
        if (w_grant_i) begin
            bus.mem_addr = bus.i_addr;
            bus.mem_be   = 4'hF;
        end else if (w_grant_d) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_be    = bus.d_be;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_streak  <= 4'd0;
            r_kill    <= 1'b0;
            r_owner_i <= 1'b0;
            r_store   <= 1'b0;
            r_i_rdata <= 32'd0;
            r_d_rdata <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_i) begin
                        r_owner_i <= 1'b1;
                        r_store   <= 1'b0;
                        r_cnt     <= c_lat_load;
                        r_streak  <= 4'd0;
                        r_state   <= S_WAIT;
                    end else if (w_grant_d) begin
                        r_owner_i <= 1'b0;
                        r_store   <= bus.d_we;
                        r_cnt     <= c_lat_load;
                        if (!bus.i_req)
                            r_streak <= 4'd0;
                        else if (r_streak != c_max_streak)
                            r_streak <= r_streak + 4'd1;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_owner_i && bus.i_kill)
                        r_kill <= 1'b1;
                    if (r_cnt == 4'd0) begin
                        // A killed fetch still drains its latency but leaves i_rdata intact.
                        if (r_owner_i) begin
                            if (!w_kill_now)
                                r_i_rdata <= bus.mem_rdata;
                        end else begin
                            r_d_rdata <= r_store ? 32'd0 : bus.mem_rdata;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_kill  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ack   = (r_state == S_DONE) & r_owner_i & ~w_kill_now;
    assign bus.d_ack   = (r_state == S_DONE) & ~r_owner_i;
    assign bus.i_rdata = r_i_rdata;
    assign bus.d_rdata = r_d_rdata;
    // The grant cycle itself already counts as busy.
    assign bus.busy    = ~w_idle | w_grant_i | w_grant_d;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter (latency 2 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arbiter_if bus0 ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.MEM_LATENCY(2), .MAX_DATA_STREAK(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    mem_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.i_req = 1'b0; bus0.i_addr = 32'd0; bus0.i_kill = 1'b0;
        bus0.d_req = 1'b0; bus0.d_we = 1'b0; bus0.d_addr = 32'd0;
        bus0.d_wdata = 32'd0; bus0.d_be = 4'd0; bus0.mem_rdata = 32'd0;
        bus1.i_req = 1'b0; bus1.i_addr = 32'd0; bus1.i_kill = 1'b0;
        bus1.d_req = 1'b0; bus1.d_we = 1'b0; bus1.d_addr = 32'd0;
        bus1.d_wdata = 32'd0; bus1.d_be = 4'd0; bus1.mem_rdata = 32'd0;

        // Reset state
        step();
        chk("rst mem_en", {31'd0, bus0.mem_en}, 32'd0);
        chk("rst busy",   {31'd0, bus0.busy},   32'd0);
        chk("rst d_ack",  {31'd0, bus0.d_ack},  32'd0);
        chk("rst i_ack",  {31'd0, bus0.i_ack},  32'd0);
        chk("rst d_rdata", bus0.d_rdata, 32'd0);
        step();
        rst = 1'b0;

        // Test 1: single load, latency 2
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h100;
        bus0.mem_rdata = 32'hCAFEBABE;
        #1;
        chk("t1 c0 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        chk("t1 c0 mem_we", {31'd0, bus0.mem_we}, 32'd0);
        chk("t1 c0 addr",   bus0.mem_addr, 32'h100);
        chk("t1 c0 busy",   {31'd0, bus0.busy}, 32'd1);
        step();
        chk("t1 c1 mem_en", {31'd0, bus0.mem_en}, 32'd0);
        chk("t1 c1 busy",   {31'd0, bus0.busy}, 32'd1);
        step();
        chk("t1 c2 d_ack",  {31'd0, bus0.d_ack}, 32'd0);
        chk("t1 c2 busy",   {31'd0, bus0.busy}, 32'd1);
        step();
        chk("t1 c3 d_ack",  {31'd0, bus0.d_ack}, 32'd1);
        chk("t1 c3 d_rdata", bus0.d_rdata, 32'hCAFEBABE);
        chk("t1 c3 busy",   {31'd0, bus0.busy}, 32'd1);
        chk("t1 c3 mem_en", {31'd0, bus0.mem_en}, 32'd0);
        bus0.d_req = 1'b0;
        step();
        chk("t1 c4 busy",   {31'd0, bus0.busy}, 32'd0);
        chk("t1 c4 d_ack",  {31'd0, bus0.d_ack}, 32'd0);

        // Test 2: simultaneous store and fetch, data first
        bus0.i_req = 1'b1; bus0.i_addr = 32'h0;
        bus0.d_req = 1'b1; bus0.d_we = 1'b1; bus0.d_addr = 32'h200;
        bus0.d_be = 4'b0011; bus0.d_wdata = 32'h1234;
        bus0.mem_rdata = 32'h11111111;
        #1;
        chk("t2 c0 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        chk("t2 c0 mem_we", {31'd0, bus0.mem_we}, 32'd1);
        chk("t2 c0 be",     {28'd0, bus0.mem_be}, 32'h3);
        chk("t2 c0 addr",   bus0.mem_addr, 32'h200);
        chk("t2 c0 wdata",  bus0.mem_wdata, 32'h1234);
        step(); step(); step();
        chk("t2 c3 d_ack",  {31'd0, bus0.d_ack}, 32'd1);
        chk("t2 c3 i_ack",  {31'd0, bus0.i_ack}, 32'd0);
        chk("t2 c3 d_rdata", bus0.d_rdata, 32'd0);
        bus0.d_req = 1'b0;
        step();
        chk("t2 c4 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        chk("t2 c4 mem_we", {31'd0, bus0.mem_we}, 32'd0);
        chk("t2 c4 be",     {28'd0, bus0.mem_be}, 32'hF);
        chk("t2 c4 addr",   bus0.mem_addr, 32'h0);
        step(); step();
        chk("t2 c6 i_ack",  {31'd0, bus0.i_ack}, 32'd0);
        step();
        chk("t2 c7 i_ack",  {31'd0, bus0.i_ack}, 32'd1);
        chk("t2 c7 d_ack",  {31'd0, bus0.d_ack}, 32'd0);
        chk("t2 c7 i_rdata", bus0.i_rdata, 32'h11111111);
        bus0.i_req = 1'b0;
        step();

        // Test 3: starvation bound with both requests held
        bus0.i_req = 1'b1; bus0.i_addr = 32'h40;
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h300;
        #1;
        for (int c = 0; c < 24; c++) begin
            logic exp_en;
            exp_en = ((c % 4) == 0) && (c <= 20);
            chk($sformatf("t3 c%0d mem_en", c), {31'd0, bus0.mem_en}, {31'd0, exp_en});
            if (exp_en)
                chk($sformatf("t3 c%0d addr", c), bus0.mem_addr, (c == 16) ? 32'h40 : 32'h300);
            if (c == 19)
                chk("t3 c19 i_ack", {31'd0, bus0.i_ack}, 32'd1);
            if (c == 23) begin
                chk("t3 c23 d_ack", {31'd0, bus0.d_ack}, 32'd1);
                bus0.d_req = 1'b0;
                bus0.i_req = 1'b0;
            end
            step();
        end

        // Test 4: kill an in-flight fetch
        bus0.i_req = 1'b1; bus0.i_addr = 32'h80;
        bus0.mem_rdata = 32'h22222222;
        #1;
        chk("t4 c0 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        chk("t4 c0 addr",   bus0.mem_addr, 32'h80);
        step();
        bus0.i_kill = 1'b1;
        step();
        bus0.i_kill = 1'b0;
        step();
        chk("t4 c3 i_ack",  {31'd0, bus0.i_ack}, 32'd0);
        chk("t4 c3 i_rdata", bus0.i_rdata, 32'h11111111);
        bus0.i_addr = 32'h40;
        step();
        chk("t4 c4 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        chk("t4 c4 addr",   bus0.mem_addr, 32'h40);
        step(); step(); step();
        chk("t4 c7 i_ack",  {31'd0, bus0.i_ack}, 32'd1);
        chk("t4 c7 i_rdata", bus0.i_rdata, 32'h22222222);
        bus0.i_req = 1'b0;
        step();

        // Test 5: asynchronous reset mid-access
        bus0.d_req = 1'b1; bus0.d_we = 1'b0; bus0.d_addr = 32'h500;
        bus0.mem_rdata = 32'h33333333;
        #1;
        chk("t5 c0 mem_en", {31'd0, bus0.mem_en}, 32'd1);
        step();
        rst = 1'b1;
        #1;
        chk("t5 rst mem_en", {31'd0, bus0.mem_en}, 32'd0);
        chk("t5 rst busy",   {31'd0, bus0.busy}, 32'd0);
        chk("t5 rst addr",   bus0.mem_addr, 32'd0);
        chk("t5 rst d_rdata", bus0.d_rdata, 32'd0);
        chk("t5 rst i_rdata", bus0.i_rdata, 32'd0);
        step();
        chk("t5 c2 d_ack",   {31'd0, bus0.d_ack}, 32'd0);
        chk("t5 c2 mem_en",  {31'd0, bus0.mem_en}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("t5 c3 d_ack",   {31'd0, bus0.d_ack}, 32'd0);
        chk("t5 c3 mem_en",  {31'd0, bus0.mem_en}, 32'd1);
        chk("t5 c3 addr",    bus0.mem_addr, 32'h500);
        step();
        chk("t5 c4 busy",    {31'd0, bus0.busy}, 32'd1);
        chk("t5 c4 d_ack",   {31'd0, bus0.d_ack}, 32'd0);
        step(); step();
        chk("t5 c6 d_ack",   {31'd0, bus0.d_ack}, 32'd1);
        chk("t5 c6 d_rdata", bus0.d_rdata, 32'h33333333);
        bus0.d_req = 1'b0;
        step();

        // Test 6: latency 1, back-to-back fetches
        bus1.i_req = 1'b1; bus1.i_addr = 32'h10;
        bus1.mem_rdata = 32'hA5A5A5A5;
        #1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("t6 c%0d mem_en", c), {31'd0, bus1.mem_en},
                {31'd0, (c == 0) || (c == 3)});
            chk($sformatf("t6 c%0d i_ack", c), {31'd0, bus1.i_ack},
                {31'd0, (c == 2) || (c == 5)});
            if (c == 2)
                chk("t6 c2 i_rdata", bus1.i_rdata, 32'hA5A5A5A5);
            if (c == 5)
                bus1.i_req = 1'b0;
            step();
        end
        chk("t6 idle busy", {31'd0, bus1.busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
